// File: rtl/puf_resp_sequencer.sv
// Purpose : sequences one RO-pair PUF generator through settle/measure/sample phases
//           and majority-votes VOTES samples per bit into an N_BITS response word.
// Latency : resp_valid 1 + N_BITS*VOTES*(SETTLE+WINDOW+3) cycles after the accepted start.
// Backpr. : none; start is only honoured in IDLE, requests arriving otherwise are dropped.
// Ports   : clk/rst (sync, active-high); start + challenge from key logic;
//           puf_bit from generator (async, synchronized here); puf_enable/puf_challenge
//           to generator; busy, resp_valid pulse, response and resp_unstable to key logic.
module puf_resp_sequencer #(
  parameter int N_BITS = 8,
  parameter int WINDOW = 1024,
  parameter int SETTLE = 4,
  parameter int VOTES  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*N_BITS-1:0] challenge,
  input  logic                puf_bit,
  output logic                puf_enable,
  output logic [1:0]          puf_challenge,
  output logic                busy,
  output logic                resp_valid,
  output logic [N_BITS-1:0]   response,
  output logic [N_BITS-1:0]   resp_unstable
);

  // Phase counter also has to reach 2 for the 3-cycle sample phase.
  localparam int CMAX0 = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int CMAX  = (CMAX0 > 3) ? CMAX0 : 3;
  localparam int CW    = $clog2(CMAX + 1);
  localparam int OW    = $clog2(VOTES + 1);
  localparam int BW    = $clog2(N_BITS + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'(WINDOW - 1);
  localparam logic [CW-1:0] SAMP_LAST   = CW'(2);
  localparam logic [OW-1:0] VOTE_LAST   = OW'(VOTES - 1);
  localparam logic [OW-1:0] VOTE_ALL    = OW'(VOTES);
  localparam logic [OW-1:0] VOTE_HALF   = OW'(VOTES / 2);
  localparam logic [BW-1:0] BIT_LAST    = BW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt;
  logic [OW-1:0]       vote_idx;
  logic [OW-1:0]       ones;
  logic [OW-1:0]       ones_final;
  logic [BW-1:0]       bit_idx;
  logic [2*N_BITS-1:0] chal_q;
  logic                sync1, sync2;
  logic                enable_next;
  logic                accept;
  logic                vote_end;
  logic                last_vote;
  logic                last_bit;

  assign accept     = (state == S_IDLE) && start;
  assign vote_end   = (state == S_SAMPLE) && (cnt == SAMP_LAST);
  assign last_vote  = (vote_idx == VOTE_LAST);
  assign last_bit   = (bit_idx == BIT_LAST);
  // Tally including the sample taken in this cycle.
  assign ones_final = ones + OW'(sync2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_SETTLE;
      S_SETTLE:  if (cnt == SETTLE_LAST) state_next = S_MEASURE;
      S_MEASURE: if (cnt == WIN_LAST) state_next = S_SAMPLE;
      S_SAMPLE:  if (cnt == SAMP_LAST)
                   state_next = (last_vote && last_bit) ? S_DONE : S_SETTLE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode; enable is decoded from the next state so the register lines up with state.
  always_comb begin
    busy        = (state == S_SETTLE) || (state == S_MEASURE) || (state == S_SAMPLE);
    resp_valid  = (state == S_DONE);
    enable_next = (state_next == S_MEASURE) || (state_next == S_SAMPLE);
  end

  // Datapath: synchronizer, phase counter, vote tally, response word
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      puf_enable    <= 1'b0;
      puf_challenge <= 2'b00;
      cnt           <= '0;
      vote_idx      <= '0;
      ones          <= '0;
      bit_idx       <= '0;
      chal_q        <= '0;
      response      <= '0;
      resp_unstable <= '0;
    end else begin
      sync1      <= puf_bit;
      sync2      <= sync1;
      puf_enable <= enable_next;
      // Restart the phase counter on every state change and outside active phases.
      cnt <= (busy && (state_next == state)) ? cnt + CW'(1) : '0;

      if (accept) begin
        chal_q        <= challenge;
        puf_challenge <= challenge[1:0];
        bit_idx       <= '0;
        vote_idx      <= '0;
        ones          <= '0;
        response      <= '0;
        resp_unstable <= '0;
      end else if (vote_end) begin
        if (!last_vote) begin
          ones     <= ones_final;
          vote_idx <= vote_idx + OW'(1);
        end else begin
          response[bit_idx]      <= (ones_final > VOTE_HALF);
          resp_unstable[bit_idx] <= (ones_final != '0) && (ones_final != VOTE_ALL);
          ones                   <= '0;
          vote_idx               <= '0;
          if (!last_bit) begin
            bit_idx       <= bit_idx + BW'(1);
            puf_challenge <= chal_q[2*(int'(bit_idx) + 1) +: 2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_sequencer.sv
// Purpose : self-checking bench for puf_resp_sequencer (N_BITS=4, WINDOW=16, SETTLE=2, VOTES=3).
// Latency : expects resp_valid 253 cycles after the cycle that accepts start.
// Backpr. : n/a; drives start pulses while busy and checks they are dropped.
module tb_puf_resp_sequencer;

  localparam int NB       = 4;
  localparam int WIN      = 16;
  localparam int ST       = 2;
  localparam int NV       = 3;
  localparam int VOTE_CYC = ST + WIN + 3;           // 21
  localparam int BIT_CYC  = NV * VOTE_CYC;          // 63
  localparam int LAT      = 1 + NB * BIT_CYC;       // 253

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [2*NB-1:0] challenge;
  logic            puf_bit;
  logic            puf_enable;
  logic [1:0]      puf_challenge;
  logic            busy;
  logic            resp_valid;
  logic [NB-1:0]   response;
  logic [NB-1:0]   resp_unstable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  puf_resp_sequencer #(
    .N_BITS(NB), .WINDOW(WIN), .SETTLE(ST), .VOTES(NV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .puf_bit(puf_bit),
    .puf_enable(puf_enable), .puf_challenge(puf_challenge), .busy(busy),
    .resp_valid(resp_valid), .response(response), .resp_unstable(resp_unstable)
  );

  // pat bit (b*NV + v) is the generator output during vote v of response bit b.
  typedef struct {
    logic [2*NB-1:0] chal;
    logic [NB*NV-1:0] pat;
    logic [NB-1:0]   resp;
    logic [NB-1:0]   unst;
    bit              pokes;   // re-pulse start mid-request and in DONE
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: majority of votes per bit, unstable if votes disagree.
  function automatic void model(input logic [NB*NV-1:0] pat,
                                output logic [NB-1:0] r, output logic [NB-1:0] u);
    r = '0;
    u = '0;
    for (int b = 0; b < NB; b++) begin
      int n;
      n = 0;
      for (int v = 0; v < NV; v++) n += int'(pat[b*NV + v]);
      r[b] = (n > NV / 2);
      u[b] = (n != 0) && (n != NV);
    end
  endfunction

  // One full request; timeline cycle 0 = cycle in which start is accepted.
  task automatic run_req(input vec_t v, input string tag);
    logic [NB-1:0] held_resp;
    @(negedge clk);
    challenge = v.chal;
    start     = 1'b1;
    puf_bit   = v.pat[0];
    for (int c = 1; c <= LAT + 1; c++) begin
      int k;
      int b;
      @(negedge clk);
      start     = v.pokes && (c == 50 || c == LAT);
      challenge = 8'($urandom);
      k = (c - 1) / VOTE_CYC;
      if (k > NB * NV - 1) k = NB * NV - 1;
      puf_bit = v.pat[k];
      b = (c - 1) / BIT_CYC;
      if (c < LAT) begin
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".enable"}, 32'(puf_enable), 32'(((c - 1) % VOTE_CYC) >= ST));
        chk({tag, ".valid_early"}, 32'(resp_valid), 32'd0);
        if ((c - 1) % BIT_CYC == 5 || (c - 1) % BIT_CYC == BIT_CYC - 1)
          chk({tag, ".chal_slice"}, 32'(puf_challenge), 32'(v.chal[2*b +: 2]));
      end else if (c == LAT) begin
        chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
        chk({tag, ".busy_done"}, 32'(busy), 32'd0);
        chk({tag, ".enable_done"}, 32'(puf_enable), 32'd0);
        chk({tag, ".response"}, 32'(response), 32'(v.resp));
        chk({tag, ".unstable"}, 32'(resp_unstable), 32'(v.unst));
        held_resp = response;
      end else begin
        chk({tag, ".valid_pulse"}, 32'(resp_valid), 32'd0);
        chk({tag, ".busy_idle"}, 32'(busy), 32'd0);
        chk({tag, ".resp_hold"}, 32'(response), 32'(held_resp));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    vec_t rv;
    int   seen;

    // Expected values below derived by hand from the voting rules.
    tbl[0] = '{chal: 8'b11_10_01_00, pat: 12'hFFF, resp: 4'hF,    unst: 4'h0,    pokes: 1'b0};
    tbl[1] = '{chal: 8'b11_10_01_00, pat: 12'hE38, resp: 4'b1010, unst: 4'h0,    pokes: 1'b0};
    tbl[2] = '{chal: 8'b11_10_01_00, pat: 12'h040, resp: 4'b0000, unst: 4'b0100, pokes: 1'b0};
    tbl[3] = '{chal: 8'b11_10_01_00, pat: 12'h0C0, resp: 4'b0100, unst: 4'b0100, pokes: 1'b1};
    tbl[4] = '{chal: 8'b00_01_10_11, pat: 12'h1F1, resp: 4'b0110, unst: 4'b0011, pokes: 1'b0};
    tbl[5] = '{chal: 8'b01_11_00_10, pat: 12'h000, resp: 4'b0000, unst: 4'b0000, pokes: 1'b1};

    rst = 1'b1; start = 1'b0; puf_bit = 1'b0; challenge = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.enable",   32'(puf_enable),    32'd0);
    chk("rst.chal",     32'(puf_challenge), 32'd0);
    chk("rst.busy",     32'(busy),          32'd0);
    chk("rst.valid",    32'(resp_valid),    32'd0);
    chk("rst.response", 32'(response),      32'd0);
    chk("rst.unstable", 32'(resp_unstable), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle.enable", 32'(puf_enable), 32'd0);
      chk("idle.busy",   32'(busy),       32'd0);
    end

    for (int i = 0; i < 6; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      rv.chal  = 8'($urandom);
      rv.pat   = 12'($urandom);
      rv.pokes = 1'($urandom_range(0, 1));
      model(rv.pat, rv.resp, rv.unst);
      run_req(rv, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a request.
    @(negedge clk);
    challenge = 8'b11_10_01_00;
    start     = 1'b1;
    puf_bit   = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 100) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.enable",   32'(puf_enable),    32'd0);
    chk("midrst.busy",     32'(busy),          32'd0);
    chk("midrst.valid",    32'(resp_valid),    32'd0);
    chk("midrst.response", 32'(response),      32'd0);
    chk("midrst.unstable", 32'(resp_unstable), 32'd0);
    chk("midrst.chal",     32'(puf_challenge), 32'd0);
    seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (resp_valid || busy || puf_enable) seen++;
    end
    chk("midrst.quiet", 32'(seen), 32'd0);
    run_req(tbl[4], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
